// File: rtl/mem_issue_block_pkg.sv
// mem_issue_block_pkg: shared opcode/state encodings and default widths for the memory issue block
package mem_issue_block_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAG_WIDTH = 6;
  typedef enum logic [1:0] {OP_LW = 2'b00, OP_SW = 2'b01, OP_LB = 2'b10, OP_SB = 2'b11} opcode_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_CDB = 2'd2} state_e;
  function automatic logic is_store(logic [1:0] op);
    return op[0];
  endfunction
  function automatic logic is_byte(logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/mem_issue_block_if.sv
// mem_issue_block_if: issue-queue head, data-memory port and CDB port of the memory issue block
interface mem_issue_block_if import mem_issue_block_pkg::*; #(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int TW = DEF_TAG_WIDTH
);
  logic          issueque_ready;
  logic [DW-1:0] issueque_address;
  logic [DW-1:0] issueque_rs2_data;
  logic [TW-1:0] issueque_rd_tag;
  logic [1:0]    issueque_opcode;
  logic          issueblk_done;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          cdb_req;
  logic [TW-1:0] cdb_out_tag;
  logic [DW-1:0] cdb_out_data;
  logic          cdb_grant;
  logic          busy;
  modport slave (
    input  issueque_ready, issueque_address, issueque_rs2_data, issueque_rd_tag, issueque_opcode,
    input  mem_ack, mem_rdata, cdb_grant,
    output issueblk_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output cdb_req, cdb_out_tag, cdb_out_data, busy
  );
  modport master (
    output issueque_ready, issueque_address, issueque_rs2_data, issueque_rd_tag, issueque_opcode,
    output mem_ack, mem_rdata, cdb_grant,
    input  issueblk_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  cdb_req, cdb_out_tag, cdb_out_data, busy
  );
endinterface

// File: rtl/mem_issue_block_lsu_data_align.sv
// lsu_data_align: byte enables, store-data replication and load-result extraction for word/byte accesses
module lsu_data_align import mem_issue_block_pkg::*; #(
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic [1:0]    op,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] rs2,
  input  logic [DW-1:0] rdata,
  output logic [3:0]    be,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] ld_data
);
  logic [7:0] ld_byte;
  always_comb begin
    ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    be = is_byte(op) ? 4'b0001 << addr_lo : 4'b1111;
    wdata = is_byte(op) ? {(DW/8){rs2[7:0]}} : rs2;
    ld_data = is_byte(op) ? {{(DW-8){ld_byte[7]}}, ld_byte} : rdata;
  end
endmodule

// File: rtl/mem_issue_block_register.sv
// mem_issue_block_register: plain D register with active-low asynchronous clear
module mem_issue_block_register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= d;
endmodule

// File: rtl/mem_issue_block.sv
// mem_issue_block: pops the load/store queue head, performs the memory access and broadcasts load results on the CDB
module mem_issue_block import mem_issue_block_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input logic clk,
  input logic reset,
  mem_issue_block_if.slave bus
);
  localparam int FW = 3*DATA_WIDTH + 2*TAG_WIDTH + 2;
  state_e state_q, state_d;
  logic [1:0] state_raw;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, data_q, data_d, cdata_q, cdata_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, ctag_q, ctag_d;
  logic [1:0] op_q, op_d;
  logic done, mem_req;
  logic [3:0] be;
  logic [DATA_WIDTH-1:0] wdata, ld_data;
  mem_issue_block_register #(.W(2)) u_state (.clk(clk), .rst_n(reset), .d(state_d), .q(state_raw));
  mem_issue_block_register #(.W(FW)) u_fields (
    .clk(clk), .rst_n(reset),
    .d({addr_d, data_d, tag_d, op_d, ctag_d, cdata_d}),
    .q({addr_q, data_q, tag_q, op_q, ctag_q, cdata_q})
  );
  lsu_data_align #(.DW(DATA_WIDTH)) u_align (
    .op(op_q), .addr_lo(addr_q[1:0]), .rs2(data_q), .rdata(bus.mem_rdata),
    .be(be), .wdata(wdata), .ld_data(ld_data)
  );
  assign state_q = state_e'(state_raw);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    tag_d = tag_q;
    op_d = op_q;
    ctag_d = ctag_q;
    cdata_d = cdata_q;
    done = reset && state_q == S_IDLE && bus.issueque_ready;
    case (state_q)
      S_IDLE: if (done) begin
        addr_d = bus.issueque_address;
        data_d = bus.issueque_rs2_data;
        tag_d = bus.issueque_rd_tag;
        op_d = bus.issueque_opcode;
        state_d = S_MEM;
      end
      S_MEM: if (bus.mem_ack) begin
        state_d = is_store(op_q) ? S_IDLE : S_CDB;
        ctag_d = is_store(op_q) ? ctag_q : tag_q;
        cdata_d = is_store(op_q) ? cdata_q : ld_data;
      end
      S_CDB: state_d = bus.cdb_grant ? S_IDLE : S_CDB;
      default: state_d = S_IDLE;
    endcase
  end
  assign mem_req = state_q == S_MEM;
  assign bus.issueblk_done = done;
  assign bus.mem_req = mem_req;
  assign bus.mem_we = mem_req && is_store(op_q);
  assign bus.mem_addr = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = mem_req ? wdata : '0;
  assign bus.mem_be = mem_req ? be : 4'b0000;
  assign bus.cdb_req = state_q == S_CDB;
  assign bus.cdb_out_tag = ctag_q;
  assign bus.cdb_out_data = cdata_q;
  assign bus.busy = state_q != S_IDLE;
endmodule

// File: tb/tb_mem_issue_block.sv
// tb_mem_issue_block: directed load/store scenarios checked against a transaction-level model every cycle
module tb_mem_issue_block;
  import mem_issue_block_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mem_issue_block_if bus ();
  mem_issue_block dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  int ph = 0;
  logic [31:0] m_a = '0, m_d = '0, e_data = '0;
  logic [5:0] m_tag = '0, e_tag = '0;
  logic [1:0] m_op = '0;
  logic [31:0] wr_log[$];
  int done_cyc[$];
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] load_val(logic [1:0] op, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    if (op != OP_LB) return rd;
    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
  endfunction
  // transaction model: idle -> memory access -> (loads only) broadcast
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; m_a = '0; m_d = '0; m_tag = '0; m_op = '0; e_tag = '0; e_data = '0;
    end else if (ph == 0) begin
      if (bus.issueque_ready) begin
        m_a = bus.issueque_address; m_d = bus.issueque_rs2_data;
        m_tag = bus.issueque_rd_tag; m_op = bus.issueque_opcode; ph = 1;
      end
    end else if (ph == 1) begin
      if (bus.mem_ack) begin
        if (m_op == OP_SW || m_op == OP_SB) ph = 0;
        else begin
          e_tag = m_tag; e_data = load_val(m_op, m_a, bus.mem_rdata); ph = 2;
        end
      end
    end else if (bus.cdb_grant) ph = 0;
  end
  initial forever begin
    logic st, by;
    @(negedge clk);
    #1;
    st = (m_op == OP_SW || m_op == OP_SB);
    by = (m_op == OP_LB || m_op == OP_SB);
    chk("done", bus.issueblk_done, reset && ph == 0 && bus.issueque_ready);
    chk("mem_req", bus.mem_req, ph == 1);
    chk("mem_we", bus.mem_we, ph == 1 && st);
    chk("mem_addr", bus.mem_addr, ph == 1 ? m_a & ~32'h3 : 32'h0);
    chk("mem_be", bus.mem_be, ph == 1 ? (by ? 32'h1 << (m_a % 4) : 32'hF) : 32'h0);
    if (ph == 1 && st) chk("mem_wdata", bus.mem_wdata, m_op == OP_SB ? (m_d & 32'hFF) * 32'h0101_0101 : m_d);
    chk("cdb_req", bus.cdb_req, ph == 2);
    chk("cdb_tag", bus.cdb_out_tag, e_tag);
    chk("cdb_data", bus.cdb_out_data, e_data);
    chk("busy", bus.busy, ph != 0);
    if (bus.issueblk_done) done_cyc.push_back(cyc);
    if (bus.mem_req && bus.mem_we && bus.mem_ack) wr_log.push_back(bus.mem_addr);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic sample;
    @(negedge clk);
    #2;
  endtask
  task automatic pop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [5:0] t);
    bus.issueque_ready = 1'b1;
    bus.issueque_opcode = op;
    bus.issueque_address = a;
    bus.issueque_rs2_data = d;
    bus.issueque_rd_tag = t;
  endtask
  initial begin
    bus.issueque_ready = 0; bus.issueque_address = 0; bus.issueque_rs2_data = 0;
    bus.issueque_rd_tag = 0; bus.issueque_opcode = 0; bus.mem_ack = 0; bus.mem_rdata = 0; bus.cdb_grant = 0;
    tick;
    bus.issueque_ready = 1; #1;
    chk("rst_done", bus.issueblk_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cdb_data", bus.cdb_out_data, 0);
    bus.issueque_ready = 0;
    tick; reset = 1;
    tick;
    pop(OP_LW, 32'h10, 0, 5); bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF; bus.cdb_grant = 1;
    sample; chk("lw_done", bus.issueblk_done, 1);
    tick; bus.issueque_ready = 0;
    sample; chk("lw_req", bus.mem_req, 1); chk("lw_addr", bus.mem_addr, 32'h10); chk("lw_be", bus.mem_be, 4'hF);
    tick;
    sample; chk("lw_cdb_req", bus.cdb_req, 1); chk("lw_tag", bus.cdb_out_tag, 5); chk("lw_data", bus.cdb_out_data, 32'hDEAD_BEEF);
    tick;
    sample; chk("lw_idle", bus.busy, 0); chk("lw_hold", bus.cdb_out_data, 32'hDEAD_BEEF);
    bus.mem_ack = 0; bus.cdb_grant = 0;
    tick; pop(OP_SB, 32'h23, 32'hA5, 7);
    sample; chk("sb_done", bus.issueblk_done, 1);
    tick; bus.issueque_ready = 0;
    sample; chk("sb_we", bus.mem_we, 1); chk("sb_addr", bus.mem_addr, 32'h20);
    chk("sb_be", bus.mem_be, 4'b1000); chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.mem_ack = 1;
    tick;
    sample; chk("sb_idle", bus.busy, 0); chk("sb_nocdb", bus.cdb_req, 0);
    tick; pop(OP_SW, 32'h13, 32'h1234_5678, 1);
    sample; tick; bus.issueque_ready = 0;
    sample; chk("sw_ua_addr", bus.mem_addr, 32'h10); chk("sw_ua_be", bus.mem_be, 4'hF); chk("sw_ua_wdata", bus.mem_wdata, 32'h1234_5678);
    tick; bus.mem_ack = 0;
    pop(OP_LB, 32'h41, 0, 9); bus.mem_rdata = 32'h0000_8000;
    sample; chk("lb_done", bus.issueblk_done, 1);
    tick; bus.issueque_ready = 0;
    for (int i = 0; i < 5; i++) begin
      sample; chk("lb_req", bus.mem_req, 1); chk("lb_addr", bus.mem_addr, 32'h40); chk("lb_be", bus.mem_be, 4'b0010);
      if (i == 4) bus.mem_ack = 1;
      tick;
    end
    bus.mem_ack = 0;
    pop(OP_SW, 32'h100, 32'h1111_1111, 2);
    for (int i = 0; i < 4; i++) begin
      sample; chk("lb_cdb_req", bus.cdb_req, 1); chk("lb_block", bus.issueblk_done, 0);
      chk("lb_data", bus.cdb_out_data, 32'hFFFF_FF80); chk("lb_tag", bus.cdb_out_tag, 9);
      if (i == 3) bus.cdb_grant = 1;
      tick;
    end
    bus.cdb_grant = 0; bus.mem_ack = 1;
    sample; chk("sw1_done", bus.issueblk_done, 1);
    tick; pop(OP_SW, 32'h104, 32'h2222_2222, 3);
    sample; chk("sw1_nodone", bus.issueblk_done, 0); chk("sw1_addr", bus.mem_addr, 32'h100); chk("sw1_wdata", bus.mem_wdata, 32'h1111_1111);
    tick;
    sample; chk("sw2_done", bus.issueblk_done, 1);
    tick; bus.issueque_ready = 0;
    sample; chk("sw2_addr", bus.mem_addr, 32'h104); chk("sw2_wdata", bus.mem_wdata, 32'h2222_2222);
    tick; bus.mem_ack = 0;
    sample; chk("sw2_idle", bus.busy, 0);
    chk("done_spacing", done_cyc.size() >= 2 ? done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2] : -1, 2);
    chk("wr_order0", wr_log.size() >= 2 ? wr_log[wr_log.size()-2] : 32'hX, 32'h100);
    chk("wr_order1", wr_log.size() >= 2 ? wr_log[wr_log.size()-1] : 32'hX, 32'h104);
    tick; pop(OP_LB, 32'h42, 0, 4); bus.mem_rdata = 32'h1122_3344; bus.mem_ack = 1; bus.cdb_grant = 1;
    sample; tick; bus.issueque_ready = 0;
    tick;
    sample; chk("lb2_data", bus.cdb_out_data, 32'h0000_0022); chk("lb2_tag", bus.cdb_out_tag, 4);
    tick; bus.mem_ack = 0; bus.cdb_grant = 0;
    pop(OP_LW, 32'h200, 0, 3);
    sample; tick; bus.issueque_ready = 0;
    sample; chk("abort_req_pre", bus.mem_req, 1);
    #1 reset = 0;
    #1;
    chk("abort_req", bus.mem_req, 0); chk("abort_busy", bus.busy, 0); chk("abort_addr", bus.mem_addr, 0);
    chk("abort_cdb_data", bus.cdb_out_data, 0); chk("abort_done", bus.issueblk_done, 0);
    bus.mem_ack = 1; bus.cdb_grant = 1;
    tick; tick; reset = 1;
    repeat (3) begin
      sample; chk("post_rst_cdb", bus.cdb_req, 0); chk("post_rst_busy", bus.busy, 0);
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_issue_block.md
MEM_ISSUE_BLOCK -- requirements
Module: mem_issue_block

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of address, store data, load data and CDB data.
REQ-002 Parameter TAG_WIDTH, default 6: width of rd/CDB tags.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 issueque_ready  input  1  load/store queue head entry is valid with operands resolved.
REQ-006 issueque_address  input  32  effective address (rs1 + imm) of head entry.
REQ-007 issueque_rs2_data  input  32  store data of head entry.
REQ-008 issueque_rd_tag  input  6  destination tag of head entry.
REQ-009 issueque_opcode  input  2  00 LW, 01 SW, 10 LB (sign-extended), 11 SB.
REQ-010 issueblk_done  output  1  pops the queue head; the queue advances on issueblk_done & issueque_ready.
REQ-011 mem_req  output  1  data-memory request, held until acknowledged.
REQ-012 mem_we  output  1  1 = write, 0 = read.
REQ-013 mem_addr  output  32  word-aligned address (bits [1:0] forced to 0).
REQ-014 mem_wdata  output  32  write data, byte-replicated for SB.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_ack  input  1  memory completes the access this cycle; mem_rdata is valid with it.
REQ-017 mem_rdata  input  32  read data.
REQ-018 cdb_req  output  1  request to broadcast load result on the CDB.
REQ-019 cdb_out_tag  output  6  tag broadcast with the result.
REQ-020 cdb_out_data  output  32  load result.
REQ-021 cdb_grant  input  1  CDB arbiter accepts the broadcast this cycle.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states: IDLE, MEM, CDB.
REQ-024 issueblk_done = (state == IDLE) & issueque_ready, combinational; never asserted outside IDLE.
REQ-025 In the cycle issueblk_done is high, the block latches address, rs2_data, rd_tag and opcode, then transitions IDLE -> MEM.
REQ-026 In MEM, mem_req = 1 and mem_we/mem_addr/mem_wdata/mem_be are driven from latched registers, stable until mem_ack.
REQ-027 mem_ack is ignored outside MEM; mem_ack asserted in the first MEM cycle is honoured (single-cycle memory allowed).
REQ-028 LW/SW: mem_be = 4'b1111; SW drives mem_wdata = rs2_data.
REQ-029 LB/SB: mem_be = one-hot (1 << addr[1:0]); SB drives mem_wdata = {4{rs2_data[7:0]}}.
REQ-030 MEM + mem_ack + store -> IDLE; no CDB activity for stores.
REQ-031 MEM + mem_ack + load -> CDB; cdb_out_data registered on that edge: LW = mem_rdata; LB = sign-extend of the byte selected by addr[1:0].
REQ-032 In CDB, cdb_req = 1 with cdb_out_tag = latched rd_tag; it holds until cdb_grant, then -> IDLE.
REQ-033 Minimum latency: store 2 cycles, load 3 cycles, issueblk_done to return to IDLE.
REQ-034 Back-to-back: the next pop may occur in the first IDLE cycle after completion; no dead cycle beyond IDLE is required.
REQ-035 Unaligned LW/SW: address bits [1:0] are dropped; no exception is raised.
REQ-036 Outputs not named active in the current state (mem_*, cdb_req) are driven 0 except cdb_out_tag/cdb_out_data, which hold their last value.

Reset
REQ-037 reset low asynchronously forces state IDLE and clears all latched registers.
REQ-038 During reset, all outputs are 0, including issueblk_done.
REQ-039 reset asserted mid-operation (MEM or CDB) abandons the in-flight access with no completion and no CDB broadcast.

Structure
REQ-040 A shared package holds the opcode encodings (LW, SW, LB, SB), the FSM state encoding, and the DATA_WIDTH/TAG_WIDTH defaults.
REQ-041 One combinational sub-module, lsu_data_align, produces mem_be and mem_wdata from opcode/addr/rs2, and the load result from opcode/addr/mem_rdata.
REQ-042 State and latched fields use the existing Register block with an active-low async reset.

Verification
REQ-043 LW at 0x0000_0010, tag 5, mem_ack on the 1st MEM cycle, rdata 0xDEAD_BEEF, cdb_grant immediately -> issueblk_done for 1 cycle, mem_addr = 0x10, mem_be = 1111, cdb_out_tag = 5, cdb_out_data = 0xDEAD_BEEF, back in IDLE after 3 cycles.
REQ-044 SB at 0x0000_0023 with rs2 = 0x0000_00A5 -> mem_we = 1, mem_addr = 0x20, mem_be = 1000, mem_wdata = 0xA5A5_A5A5, cdb_req never asserted.
REQ-045 LB at 0x0000_0041 with rdata 0x0000_8000 and mem_ack delayed 4 cycles -> request fields stable for 5 cycles, cdb_out_data = 0xFFFF_FF80.
REQ-046 Load with cdb_grant withheld 3 cycles while issueque_ready = 1 -> cdb_req held, issueblk_done stays 0 until the block returns to IDLE.
REQ-047 reset driven low during MEM -> outputs immediately 0; after release, state is IDLE and no cdb_req appears.
REQ-048 Two queued SW entries with single-cycle ack -> issueblk_done pulses exactly 2 cycles apart, both writes appear in order.
